// File: rtl/branch_predictor_pkg.sv
// Shared branch definitions: br_type encoding (also used by the execute-stage
// comparator), predictor FSM states, counter constants and the is_cond helper.
package branch_pkg;

  typedef enum logic [2:0] {
    BEQ  = 3'd0,
    BNE  = 3'd1,
    BLT  = 3'd2,
    BGE  = 3'd3,
    BLTU = 3'd4,
    BGEU = 3'd5,
    PC   = 3'd6,
    ALU  = 3'd7
  } br_type_e;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } bp_state_e;

  localparam logic [1:0] SN = 2'd0;
  localparam logic [1:0] WN = 2'd1;
  localparam logic [1:0] WT = 2'd2;
  localparam logic [1:0] ST = 2'd3;

  function automatic logic is_cond(input br_type_e t);
    return (t <= BGEU);
  endfunction

endpackage

// File: rtl/branch_predictor_sat_ctr.sv
// Combinational next-state function of a 2-bit saturating branch counter.
module bp_sat_ctr
  import branch_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       taken_i,
  output logic [1:0] ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (taken_i) begin
      if (ctr_i != ST) ctr_o = ctr_i + 2'd1;
    end else begin
      if (ctr_i != SN) ctr_o = ctr_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: direct-mapped 2-bit counter table plus BTB,
// with a sweep FSM that clears the table. Define BP_PERF_EN for perf counters.
module branch_predictor
  import branch_pkg::*;
#(
  parameter  int ENTRIES = 64,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_tbl,
  input  logic [31:0] pc_f,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  output logic        ready,
  input  logic        res_valid,
  input  logic [31:0] res_pc,
  input  logic [2:0]  res_br_type,
  input  logic        res_taken,
  input  logic [31:0] res_target,
  input  logic        res_pred_taken,
  input  logic [31:0] res_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [31:0] perf_branches,
  output logic [31:0] perf_misses
);

  localparam int TAG_W = 30 - IDX_W;

  bp_state_e        state_q, state_d;
  logic [IDX_W-1:0] sweep_q, sweep_d;

  logic             valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [1:0]       ctr_q   [ENTRIES];
  logic [31:0]      tgt_q   [ENTRIES];

  logic [IDX_W-1:0] idx_f, idx_r;
  logic [TAG_W-1:0] tag_f, tag_r;
  logic             hit_f, hit_r;
  br_type_e         br_type;
  logic [1:0]       ctr_next;
  logic             train;
  logic             set_valid, clr_valid, wr_ctr, wr_tag, wr_tgt;
  logic [1:0]       ctr_wdata;

  assign idx_f   = pc_f[IDX_W+1:2];
  assign tag_f   = pc_f[31:IDX_W+2];
  assign idx_r   = res_pc[IDX_W+1:2];
  assign tag_r   = res_pc[31:IDX_W+2];
  assign br_type = br_type_e'(res_br_type);
  assign hit_f   = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign hit_r   = valid_q[idx_r] && (tag_q[idx_r] == tag_r);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  // Sweep index wraps back to 0 on the final INIT cycle, ready for the next flush.
  always_comb begin
    state_d = state_q;
    sweep_d = '0;
    case (state_q)
      INIT: begin
        if (flush_tbl) begin
          sweep_d = '0;
        end else begin
          sweep_d = sweep_q + IDX_W'(1);
          if (sweep_q == IDX_W'(ENTRIES - 1)) state_d = RUN;
        end
      end
      RUN: begin
        if (flush_tbl) state_d = INIT;
      end
      default: state_d = INIT;
    endcase
  end

  always_comb begin
    ready = (state_q == RUN);
  end

  assign pred_taken  = ready && hit_f && ctr_q[idx_f][1];
  assign pred_target = pred_taken ? tgt_q[idx_f] : pc_f + 32'd4;

  assign mispredict  = res_valid && ((res_taken != res_pred_taken) ||
                                     (res_taken && (res_target != res_pred_target)));
  assign redirect_pc = res_taken ? res_target : res_pc + 32'd4;

  bp_sat_ctr u_sat_ctr (
    .ctr_i   (ctr_q[idx_r]),
    .taken_i (res_taken),
    .ctr_o   (ctr_next)
  );

  assign train = res_valid && ready;

  // A non-branch that hits must have aliased onto a taken entry, so drop it.
  always_comb begin
    set_valid = 1'b0;
    clr_valid = 1'b0;
    wr_ctr    = 1'b0;
    wr_tag    = 1'b0;
    wr_tgt    = 1'b0;
    ctr_wdata = ctr_next;
    if (train) begin
      if (is_cond(br_type)) begin
        if (hit_r) begin
          wr_ctr = 1'b1;
          wr_tgt = res_taken;
        end else if (res_taken) begin
          set_valid = 1'b1;
          wr_tag    = 1'b1;
          wr_tgt    = 1'b1;
          wr_ctr    = 1'b1;
          ctr_wdata = WT;
        end
      end else if (br_type == ALU) begin
        set_valid = 1'b1;
        wr_tag    = 1'b1;
        wr_tgt    = 1'b1;
        wr_ctr    = 1'b1;
        ctr_wdata = ST;
      end else if (hit_r) begin
        clr_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
    end else if (state_q == INIT) begin
      valid_q[sweep_q] <= 1'b0;
    end else if (set_valid) begin
      valid_q[idx_r] <= 1'b1;
    end else if (clr_valid) begin
      valid_q[idx_r] <= 1'b0;
    end
  end

  // Payload arrays need no reset: valid gates every use of them.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      ctr_q[sweep_q] <= WN;
    end else begin
      if (wr_ctr) ctr_q[idx_r] <= ctr_wdata;
      if (wr_tag) tag_q[idx_r] <= tag_r;
      if (wr_tgt) tgt_q[idx_r] <= res_target;
    end
  end

`ifdef BP_PERF_EN
  logic [31:0] perf_br_q, perf_miss_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_br_q   <= '0;
      perf_miss_q <= '0;
    end else begin
      if (res_valid && (br_type != PC)) perf_br_q <= perf_br_q + 32'd1;
      if (mispredict) perf_miss_q <= perf_miss_q + 32'd1;
    end
  end

  assign perf_branches = perf_br_q;
  assign perf_misses   = perf_miss_q;
`else
  assign perf_branches = 32'd0;
  assign perf_misses   = 32'd0;
`endif

endmodule
